alu_xor_pipe: RTL and testbench

- Parametrised, pipelined successor to the dual 4-bit ALU/XOR block in the user project wrapper.
- NUM_CH independent WIDTH-bit ALU channels, each with a 2-bit opcode.
- Channel results are XOR-reduced into a combined word x and a parity bit y.
- Valid/ready handshakes on input and output, with a 2-stage registered pipeline and a transaction counter.
- Driven from io_in/la_data_in inside the wrapper; results go to buf_io_out/buf_la1_data_out.

---
 rtl/alu_xor_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_alu_xor_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_xor_pipe.sv
// alu_xor_pipe: NUM_CH independent WIDTH-bit ALU channels feeding a two-stage
// valid/ready pipeline. S1 holds per-channel results, S2 adds the XOR of all
// channel results (x) and its parity (y). A free-running counter tallies
// completed output transfers.
// Optional: define ALU_PIPE_OVF_EN to add the per-channel signed overflow
// output ovf_o, which is carried through S1/S2 alongside alu_out_o.
module alu_xor_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NUM_CH*WIDTH-1:0] a_i,
  input  logic [NUM_CH*WIDTH-1:0] b_i,
  input  logic [NUM_CH*2-1:0]     sel_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NUM_CH*WIDTH-1:0] alu_out_o,
  output logic [NUM_CH-1:0]       carry_o,
  output logic [WIDTH-1:0]        x_o,
  output logic                    y_o,
  output logic [CNT_W-1:0]        op_cnt_o
`ifdef ALU_PIPE_OVF_EN
  ,
  output logic [NUM_CH-1:0]       ovf_o
`endif
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // handshake / advance
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s2_free, s1_adv, in_acc, out_xfer;

  // combinational ALU results
  logic [NUM_CH*WIDTH-1:0] alu_res;
  logic [NUM_CH-1:0]       alu_carry;
  logic [WIDTH-1:0]        op_a, op_b, op_res;
  logic [WIDTH:0]          op_ext;

  // stage registers
  logic [NUM_CH*WIDTH-1:0] s1_res_d, s1_res_q;
  logic [NUM_CH-1:0]       s1_carry_d, s1_carry_q;
  logic [NUM_CH*WIDTH-1:0] s2_res_d, s2_res_q;
  logic [NUM_CH-1:0]       s2_carry_d, s2_carry_q;
  logic [WIDTH-1:0]        s1_xor;
  logic [WIDTH-1:0]        x_d, x_q;
  logic                    y_d, y_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;

`ifdef ALU_PIPE_OVF_EN
  logic [NUM_CH-1:0]       alu_ovf;
  logic [NUM_CH-1:0]       s1_ovf_d, s1_ovf_q;
  logic [NUM_CH-1:0]       s2_ovf_d, s2_ovf_q;
`endif

  // Handshake: ready depends only on pipeline state, never on in_valid_i.
  always_comb begin
    s2_free    = ~s2_valid_q | out_ready_i;
    s1_adv     = s1_valid_q & s2_free;
    in_ready_o = ~s1_valid_q | s2_free;
    in_acc     = in_valid_i & in_ready_o;
    out_xfer   = s2_valid_q & out_ready_i;
  end

  // Per-channel ALU; the extra MSB of op_ext is carry for ADD and borrow for SUB.
  always_comb begin
    alu_res   = '0;
    alu_carry = '0;
    op_a      = '0;
    op_b      = '0;
    op_ext    = '0;
    op_res    = '0;
`ifdef ALU_PIPE_OVF_EN
    alu_ovf   = '0;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      op_a = a_i[k*WIDTH +: WIDTH];
      op_b = b_i[k*WIDTH +: WIDTH];
      case (sel_i[k*2 +: 2])
        OP_ADD:  op_ext = {1'b0, op_a} + {1'b0, op_b};
        OP_SUB:  op_ext = {1'b0, op_a} - {1'b0, op_b};
        OP_AND:  op_ext = {1'b0, op_a & op_b};
        default: op_ext = {1'b0, op_a ^ op_b};
      endcase
      op_res                   = op_ext[WIDTH-1:0];
      alu_res[k*WIDTH +: WIDTH] = op_res;
      alu_carry[k]             = op_ext[WIDTH];
`ifdef ALU_PIPE_OVF_EN
      case (sel_i[k*2 +: 2])
        OP_ADD:  alu_ovf[k] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (op_res[WIDTH-1] != op_a[WIDTH-1]);
        OP_SUB:  alu_ovf[k] = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                              (op_res[WIDTH-1] != op_a[WIDTH-1]);
        default: alu_ovf[k] = 1'b0;
      endcase
`endif
    end
  end

  // XOR-reduce the S1 channel results for the S2 combined word.
  always_comb begin
    s1_xor = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s1_xor = s1_xor ^ s1_res_q[k*WIDTH +: WIDTH];
    end
  end

  // Next-state for both stages and the transfer counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_res_d   = s1_res_q;
    s1_carry_d = s1_carry_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_carry_d = s2_carry_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
`ifdef ALU_PIPE_OVF_EN
    s1_ovf_d   = s1_ovf_q;
    s2_ovf_d   = s2_ovf_q;
`endif

    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_res_d   = alu_res;
      s1_carry_d = alu_carry;
`ifdef ALU_PIPE_OVF_EN
      s1_ovf_d   = alu_ovf;
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // A transfer and an S1 advance in the same cycle reload S2 with no bubble.
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_res_d   = s1_res_q;
      s2_carry_d = s1_carry_q;
      x_d        = s1_xor;
      y_d        = ^s1_xor;
`ifdef ALU_PIPE_OVF_EN
      s2_ovf_d   = s1_ovf_q;
`endif
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset discards anything in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_carry_q <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_carry_q <= '0;
      x_q        <= '0;
      y_q        <= 1'b0;
      cnt_q      <= '0;
`ifdef ALU_PIPE_OVF_EN
      s1_ovf_q   <= '0;
      s2_ovf_q   <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_res_q   <= s1_res_d;
      s1_carry_q <= s1_carry_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_carry_q <= s2_carry_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
`ifdef ALU_PIPE_OVF_EN
      s1_ovf_q   <= s1_ovf_d;
      s2_ovf_q   <= s2_ovf_d;
`endif
    end
  end

  // Outputs come straight from S2 so they hold still under backpressure.
  always_comb begin
    out_valid_o = s2_valid_q;
    alu_out_o   = s2_res_q;
    carry_o     = s2_carry_q;
    x_o         = x_q;
    y_o         = y_q;
    op_cnt_o    = cnt_q;
`ifdef ALU_PIPE_OVF_EN
    ovf_o       = s2_ovf_q;
`endif
  end

endmodule

// File: tb/tb_alu_xor_pipe.sv
// Bench for alu_xor_pipe (WIDTH=4, NUM_CH=2, CNT_W=4). Expected results are
// queued when a set is accepted and compared when the matching set leaves.
module tb_alu_xor_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_in = '0, b_in = '0;
  logic [3:0] sel_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] alu_out;
  logic [1:0] carry;
  logic [3:0] x;
  logic       y;
  logic [3:0] op_cnt;
  logic [1:0] ovf;

  always #5 clk = ~clk;

  alu_xor_pipe #(.WIDTH(4), .NUM_CH(2), .CNT_W(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .sel_i       (sel_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_out_o   (alu_out),
    .carry_o     (carry),
    .x_o         (x),
    .y_o         (y),
    .op_cnt_o    (op_cnt)
`ifdef ALU_PIPE_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );
`ifndef ALU_PIPE_OVF_EN
  assign ovf = 2'b00;
`endif

  typedef struct packed {
    logic [7:0] res;
    logic [1:0] carry;
    logic [3:0] x;
    logic       y;
    logic [1:0] ovf;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  logic accepted;
  logic s_in_ready, s_out_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, signed overflow via range check.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    exp_t e;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      int av, bv, r, sa, sb, sr;
      logic [1:0] op;
      av = int'(a[k*4 +: 4]);
      bv = int'(b[k*4 +: 4]);
      op = sel[k*2 +: 2];
      sa = (av > 7) ? av - 16 : av;
      sb = (bv > 7) ? bv - 16 : bv;
      r = 0;
      sr = 0;
      case (op)
        2'b00: begin r = av + bv; e.carry[k] = (r > 15); sr = sa + sb; end
        2'b01: begin r = av - bv; e.carry[k] = (av < bv); sr = sa - sb; end
        2'b10: r = av & bv;
        default: r = av ^ bv;
      endcase
      e.res[k*4 +: 4] = 4'(r & 15);
      if (op == 2'b00 || op == 2'b01) e.ovf[k] = (sr > 7) || (sr < -8);
    end
    e.x = e.res[3:0] ^ e.res[7:4];
    e.y = ^e.x;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output: got alu_out 0x%0h expected no output", alu_out);
      return;
    end
    e = sb_q.pop_front();
    chk("alu_out", 32'(alu_out), 32'(e.res));
    chk("carry", 32'(carry), 32'(e.carry));
    chk("x", 32'(x), 32'(e.x));
    chk("y", 32'(y), 32'(e.y));
`ifdef ALU_PIPE_OVF_EN
    chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
    chk("op_cnt_before_xfer", 32'(op_cnt), 32'(exp_cnt % 16));
    exp_cnt++;
  endtask

  // Called at a falling edge; drives, samples 1 time unit before the rising
  // edge, and returns at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic rdy, input exp_t e);
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    sel_in    = sel;
    out_ready = rdy;
    #4;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    accepted    = v & in_ready;
    if (accepted) sb_q.push_back(e);
    if (out_valid && rdy) check_out();
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 8'h00, 8'h00, 4'h0, rdy, '0);
  endtask

  task automatic drive_set(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                           input exp_t e);
    int tries = 0;
    do begin
      cycle(1'b1, a, b, sel, 1'b1, e);
      tries++;
    end while (!accepted && tries < 20);
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected accept within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) idle(1'b1);
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t       tbl[6];
  logic [7:0] ra, rb;
  logic [3:0] rs;
  exp_t       re;
  logic [7:0] bp_a[4], bp_b[4];
  logic [3:0] bp_s[4];
  int         idx;

  initial begin
    //           a      b      sel      res    carry  x     y     ovf
    tbl[0] = '{8'h39, 8'h58, 4'b0100, '{8'hE1, 2'b11, 4'hF, 1'b0, 2'b01}};
    tbl[1] = '{8'hCC, 8'hAA, 4'b1110, '{8'h68, 2'b00, 4'hE, 1'b1, 2'b00}};
    tbl[2] = '{8'h87, 8'h11, 4'b0100, '{8'h78, 2'b00, 4'hF, 1'b0, 2'b11}};
    tbl[3] = '{8'h03, 8'h01, 4'b0100, '{8'h04, 2'b00, 4'h4, 1'b1, 2'b00}};
    tbl[4] = '{8'h0F, 8'hFF, 4'b0100, '{8'h1E, 2'b11, 4'hF, 1'b0, 2'b00}};
    tbl[5] = '{8'hFF, 8'h0F, 4'b1011, '{8'h00, 2'b00, 4'h0, 1'b0, 2'b00}};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    rst_n = 1'b1;
    idle(1'b1);
    chk("rst_in_ready", 32'(s_in_ready), 32'd1);

    // latency: accepted set appears two rising edges later
    drive_set(tbl[0].a, tbl[0].b, tbl[0].sel, tbl[0].e);
    idle(1'b1);
    chk("latency_not_yet", 32'(s_out_valid), 32'd0);
    idle(1'b1);
    chk("latency_valid", 32'(s_out_valid), 32'd1);
    chk("op_cnt_after_first", 32'(op_cnt), 32'd1);
    drain();

    // table vectors, back to back
    for (int i = 0; i < 6; i++) drive_set(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].e);
    drain();

    // random streaming, one set per cycle
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 4'($urandom);
      re = model(ra, rb, rs);
      cycle(1'b1, ra, rb, rs, 1'b1, re);
      chk("stream_in_ready", 32'(accepted), 32'd1);
    end
    drain();
    chk("stream_op_cnt", 32'(op_cnt), 32'(15 % 16));

    // backpressure: consumer stalls, input held valid
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
      bp_s[i] = 4'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, bp_a[idx], bp_b[idx], bp_s[idx], 1'b0, model(bp_a[idx], bp_b[idx], bp_s[idx]));
      chk("bp_in_ready", 32'(s_in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (accepted) idx++;
      if (c >= 2) begin
        chk("bp_out_valid", 32'(s_out_valid), 32'd1);
        chk("bp_hold_alu_out", 32'(alu_out), 32'(sb_q[0].res));
        chk("bp_hold_x", 32'(x), 32'(sb_q[0].x));
      end
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    while (idx < 4) begin
      drive_set(bp_a[idx], bp_b[idx], bp_s[idx], model(bp_a[idx], bp_b[idx], bp_s[idx]));
      idx++;
    end
    drain();
    chk("bp_op_cnt", 32'(op_cnt), 32'(19 % 16));

    // reset mid-stream discards in-flight sets
    for (int i = 0; i < 2; i++) drive_set(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].e);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_alu_out", 32'(alu_out), 32'd0);
    chk("midrst_carry", 32'(carry), 32'd0);
    chk("midrst_xy", 32'({x, y}), 32'd0);
    chk("midrst_op_cnt", 32'(op_cnt), 32'd0);
    sb_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(1'b1);
    chk("midrst_in_ready", 32'(s_in_ready), 32'd1);
    chk("midrst_no_output", 32'(s_out_valid), 32'd0);

    // counter wrap: 17 transfers from zero with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 4'($urandom);
      drive_set(ra, rb, rs, model(ra, rb, rs));
    end
    drain();
    chk("cnt_wrap", 32'(op_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
